nvdla_dbb_duplex_bridge: RTL and testbench
==========================================

// Module: nvdla_dbb_duplex_bridge
// PURPOSE
// - Full-duplex bridge between NVDLA DBB request/data/response channels and two HWPE streamers
//   (sink = writes to memory, source = reads from memory).
// - Independent read and write FSMs run concurrently, not serialised.
// - Parametrised data/addr/id/len widths; counted multi-beat bursts; write-response generation.
// - Sticky error flag when write-data `last` disagrees with the requested length.
// PARAMETERS
// DW    32  data width (bits); strobe width DW/8
// AW    32  address width
// IDW    8  transaction id width
// LENW   4  burst length field width; len = beats-1 (1..2**LENW beats)
// PORTS
// clk_i            in   1        clock
// rst_ni           in   1        reset, asynchronous, active-low
// clear_i          in   1        synchronous soft clear
// wr_req_valid_i   in   1        write request valid
// wr_req_ready_o   out  1        write request accepted
// wr_req_addr_i    in   AW       write base address
// wr_req_len_i     in   LENW     write beats-1
// wr_req_id_i      in   IDW      write id
// wr_dat_valid_i   in   1        write data valid
// wr_dat_ready_o   out  1        write data ready
// wr_dat_data_i    in   DW       write data
// wr_dat_strb_i    in   DW/8     byte strobes
// wr_dat_last_i    in   1        last beat marker from DBB
// wr_rsp_valid_o   out  1        write response valid
// wr_rsp_ready_i   in   1        write response ready
// wr_rsp_id_o      out  IDW      id of completed write
// rd_req_valid_i   in   1        read request valid
// rd_req_ready_o   out  1        read request accepted
// rd_req_addr_i    in   AW       read base address
// rd_req_len_i     in   LENW     read beats-1
// rd_req_id_i      in   IDW      read id
// rd_dat_valid_o   out  1        read data valid
// rd_dat_ready_i   in   1        read data ready
// rd_dat_data_o    out  DW       read data
// rd_dat_id_o      out  IDW      read id
// rd_dat_last_o    out  1        final beat of burst
// snk_start_o      out  1        sink streamer start pulse
// snk_ready_i      in   1        sink streamer ready_start (idle)
// snk_addr_o       out  AW       sink base_addr
// snk_size_o       out  LENW+1   sink trans_size = len+1
// snk_valid_o/snk_ready_i_s/snk_data_o/snk_strb_o  out/in/out/out  1/1/DW/DW/8  sink stream
// src_start_o      out  1        source streamer start pulse
// src_ready_i      in   1        source streamer ready_start
// src_addr_o       out  AW       source base_addr
// src_size_o       out  LENW+1   source trans_size
// src_valid_i/src_ready_o/src_data_i  in/out/in  1/1/DW  source stream
// wr_err_o         out  1        sticky last/len mismatch
// idle_o           out  1        both FSMs idle
// BEHAVIOUR
// - Reset/clear: both FSMs IDLE; counters, captured addr/len/id and wr_err_o = 0.
//   All valid/ready/start outputs = 0; idle_o = 1.
// - Write FSM:
//   - W_IDLE: when wr_req_valid_i & snk_ready_i, in the same cycle assert wr_req_ready_o and
//     snk_start_o for 1 cycle, capture addr/len/id, cnt=0, go to W_DATA.
//   - W_DATA: combinational pass-through snk_valid_o=wr_dat_valid_i, wr_dat_ready_o=snk_ready_i_s,
//     with data/strb. Each handshake increments cnt. On handshake with cnt==len go to W_DRAIN.
//     If wr_dat_last_i != (cnt==len) on a handshake, set wr_err_o; counted len still governs.
//   - W_DRAIN: wait snk_ready_i (stores committed) -> W_RESP.
//   - W_RESP: wr_rsp_valid_o=1, wr_rsp_id_o=captured id, held stable until wr_rsp_ready_i; then W_IDLE.
// - Read FSM:
//   - R_IDLE: when rd_req_valid_i & src_ready_i, pulse rd_req_ready_o and src_start_o,
//     capture len/id, cnt=0, go to R_DATA.
//   - R_DATA: rd_dat_valid_o=src_valid_i, src_ready_o=rd_dat_ready_i, rd_dat_id_o=captured id,
//     rd_dat_last_o=(cnt==len). On handshake with cnt==len go to R_DONE.
//   - R_DONE: wait src_ready_i -> R_IDLE.
// - Latency: request accepted in the cycle it is presented (if streamer ready); data path has
//   0-cycle latency; response appears 1 cycle after the final W_DRAIN exit.
// - Width/encoding: snk/src_size_o = {1'b0,len}+1, so len=all-ones gives 2**LENW beats without
//   overflow. cnt is LENW bits and never wraps within a burst.
// - Concurrency: read and write channels are fully independent; simultaneous requests are both
//   accepted in the same cycle.
// - Requests arriving while an FSM is busy are held (ready=0); no reordering.
// - rst_ni or clear_i mid-burst aborts immediately: no response issued; the streamer must be
//   cleared by the same clear_i.
// STRUCTURE
// - nvdla_package: state_dbb_wr_t {W_IDLE,W_DATA,W_DRAIN,W_RESP}, state_dbb_rd_t {R_IDLE,R_DATA,R_DONE}.
// - Sub-module: nvdla_dbb_beat_cnt (LENW counter with clear/inc/is_last).
//   Instantiated once per channel.
// TESTING
// - Single beat write: len=0, id=0x5A, data 0xDEADBEEF, last=1 -> one snk beat, size=1,
//   wr_rsp_id_o=0x5A, wr_err_o=0.
// - Max burst read: len=15 -> src_size_o=16, 16 beats, rd_dat_last_o only on beat 16,
//   back to R_IDLE after src_ready_i.
// - Concurrent: write len=3 and read len=7 issued same cycle -> both ready pulses in same cycle,
//   streams interleave, correct ids.
// - Backpressure: toggle rd_dat_ready_i / snk_ready_i_s every cycle -> no lost or duplicated
//   beats, outputs stable while stalled.
// - Last mismatch: len=3 with wr_dat_last_i on beat 2 -> wr_err_o=1 sticky; 4 beats still
//   consumed; response issued.
// - Clear mid-burst: assert clear_i at write beat 2 of 8 -> idle_o=1 next cycle, no wr_rsp_valid_o,
//   wr_err_o=0.

Source files
------------

// File: rtl/nvdla_dbb_duplex_bridge_pkg.sv
// Shared types and default widths for the NVDLA DBB duplex bridge.
// Contents:
//   DBB_* localparams   default data/addr/id/len widths
//   state_dbb_wr_t      write-channel FSM states
//   state_dbb_rd_t      read-channel FSM states
package nvdla_dbb_duplex_bridge_pkg;

    localparam int unsigned DBB_DW   = 32;
    localparam int unsigned DBB_AW   = 32;
    localparam int unsigned DBB_IDW  = 8;
    localparam int unsigned DBB_LENW = 4;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DATA  = 2'd1,
        W_DRAIN = 2'd2,
        W_RESP  = 2'd3
    } state_dbb_wr_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_DONE = 2'd2
    } state_dbb_rd_t;

endpackage

// File: rtl/nvdla_dbb_duplex_bridge_if.sv
// DBB-side bundle of the duplex bridge: write request/data/response and
// read request/data channels.
// Modports:
//   master  the DBB initiator (drives requests, write data, response ready,
//           read-data ready)
//   slave   the bridge (drives request readies, write response, read data)
// Signal names keep the _i/_o suffixes as seen from the bridge.
interface nvdla_dbb_duplex_bridge_if
    import nvdla_dbb_duplex_bridge_pkg::*;
#(
    parameter int unsigned DW   = DBB_DW,
    parameter int unsigned AW   = DBB_AW,
    parameter int unsigned IDW  = DBB_IDW,
    parameter int unsigned LENW = DBB_LENW
) ();

    // write request
    logic            wr_req_valid_i;
    logic            wr_req_ready_o;
    logic [AW-1:0]   wr_req_addr_i;
    logic [LENW-1:0] wr_req_len_i;
    logic [IDW-1:0]  wr_req_id_i;
    // write data
    logic            wr_dat_valid_i;
    logic            wr_dat_ready_o;
    logic [DW-1:0]   wr_dat_data_i;
    logic [DW/8-1:0] wr_dat_strb_i;
    logic            wr_dat_last_i;
    // write response
    logic            wr_rsp_valid_o;
    logic            wr_rsp_ready_i;
    logic [IDW-1:0]  wr_rsp_id_o;
    // read request
    logic            rd_req_valid_i;
    logic            rd_req_ready_o;
    logic [AW-1:0]   rd_req_addr_i;
    logic [LENW-1:0] rd_req_len_i;
    logic [IDW-1:0]  rd_req_id_i;
    // read data
    logic            rd_dat_valid_o;
    logic            rd_dat_ready_i;
    logic [DW-1:0]   rd_dat_data_o;
    logic [IDW-1:0]  rd_dat_id_o;
    logic            rd_dat_last_o;

    modport master (
        output wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_id_i,
        output wr_dat_valid_i, wr_dat_data_i, wr_dat_strb_i, wr_dat_last_i,
        output wr_rsp_ready_i,
        output rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i,
        output rd_dat_ready_i,
        input  wr_req_ready_o, wr_dat_ready_o, wr_rsp_valid_o, wr_rsp_id_o,
        input  rd_req_ready_o, rd_dat_valid_o, rd_dat_data_o, rd_dat_id_o,
        input  rd_dat_last_o
    );

    modport slave (
        input  wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_id_i,
        input  wr_dat_valid_i, wr_dat_data_i, wr_dat_strb_i, wr_dat_last_i,
        input  wr_rsp_ready_i,
        input  rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i,
        input  rd_dat_ready_i,
        output wr_req_ready_o, wr_dat_ready_o, wr_rsp_valid_o, wr_rsp_id_o,
        output rd_req_ready_o, rd_dat_valid_o, rd_dat_data_o, rd_dat_id_o,
        output rd_dat_last_o
    );

endinterface

// File: rtl/nvdla_dbb_beat_cnt.sv
// Burst beat counter for one bridge channel.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          synchronous return to zero (wins over inc_i)
//   inc_i          count one accepted beat
//   len_i          burst length as beats-1
//   is_last_o      current beat is the final one of the burst (cnt == len)
module nvdla_dbb_beat_cnt
    import nvdla_dbb_duplex_bridge_pkg::*;
#(
    parameter int unsigned LENW = DBB_LENW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic [LENW-1:0] len_i,
    output logic            is_last_o
);

    logic [LENW-1:0] cnt_q, cnt_d;

    // The owner clears on the final beat, so the count never wraps inside
    // a burst even when len is all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + LENW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_last_o = (cnt_q == len_i);

endmodule

// File: rtl/nvdla_dbb_duplex_bridge.sv
// Full-duplex bridge between the NVDLA DBB channels and two HWPE streamers.
// Writes go to the sink streamer, reads come from the source streamer; the
// two channels have independent FSMs and run concurrently.
// Ports:
//   clk_i, rst_ni, clear_i      clock, async active-low reset, sync soft clear
//   dbb                         DBB request/data/response bundle (slave side)
//   snk_start_o/snk_ready_i     sink streamer start pulse / idle indication
//   snk_addr_o/snk_size_o       sink base address / beat count (len+1)
//   snk_valid_o/snk_ready_i_s   sink stream handshake, snk_data_o/snk_strb_o
//   src_start_o/src_ready_i     source streamer start pulse / idle indication
//   src_addr_o/src_size_o       source base address / beat count (len+1)
//   src_valid_i/src_ready_o     source stream handshake, src_data_i
//   wr_err_o                    sticky: write 'last' disagreed with length
//   idle_o                      both channel FSMs idle
module nvdla_dbb_duplex_bridge
    import nvdla_dbb_duplex_bridge_pkg::*;
#(
    parameter int unsigned DW   = DBB_DW,
    parameter int unsigned AW   = DBB_AW,
    parameter int unsigned IDW  = DBB_IDW,
    parameter int unsigned LENW = DBB_LENW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,

    nvdla_dbb_duplex_bridge_if.slave dbb,

    output logic             snk_start_o,
    input  logic             snk_ready_i,
    output logic [AW-1:0]    snk_addr_o,
    output logic [LENW:0]    snk_size_o,
    output logic             snk_valid_o,
    input  logic             snk_ready_i_s,
    output logic [DW-1:0]    snk_data_o,
    output logic [DW/8-1:0]  snk_strb_o,

    output logic             src_start_o,
    input  logic             src_ready_i,
    output logic [AW-1:0]    src_addr_o,
    output logic [LENW:0]    src_size_o,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  logic [DW-1:0]    src_data_i,

    output logic             wr_err_o,
    output logic             idle_o
);

    localparam logic [LENW:0] ONE = {{LENW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_dbb_wr_t   wr_state_q, wr_state_d;
    logic [AW-1:0]   wr_addr_q,  wr_addr_d;
    logic [LENW-1:0] wr_len_q,   wr_len_d;
    logic [IDW-1:0]  wr_id_q,    wr_id_d;
    logic            wr_err_q,   wr_err_d;

    state_dbb_rd_t   rd_state_q, rd_state_d;
    logic [AW-1:0]   rd_addr_q,  rd_addr_d;
    logic [LENW-1:0] rd_len_q,   rd_len_d;
    logic [IDW-1:0]  rd_id_q,    rd_id_d;

    logic wr_cnt_clr, wr_cnt_inc, wr_is_last;
    logic rd_cnt_clr, rd_cnt_inc, rd_is_last;

    // ------------------------------------------------------------------
    // Beat counters: index 0 = write channel, index 1 = read channel
    // ------------------------------------------------------------------
    logic [1:0]      cnt_clr, cnt_inc, cnt_last;
    logic [LENW-1:0] cnt_len [2];

    assign cnt_clr    = {rd_cnt_clr, wr_cnt_clr};
    assign cnt_inc    = {rd_cnt_inc, wr_cnt_inc};
    assign cnt_len[0] = wr_len_q;
    assign cnt_len[1] = rd_len_q;
    assign wr_is_last = cnt_last[0];
    assign rd_is_last = cnt_last[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_beat_cnt
            nvdla_dbb_beat_cnt #(
                .LENW (LENW)
            ) u_beat_cnt (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clr_i     (cnt_clr[gi]),
                .inc_i     (cnt_inc[gi]),
                .len_i     (cnt_len[gi]),
                .is_last_o (cnt_last[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    // While idle the streamer sees the request fields directly so that
    // base address and size are valid in the same cycle as the start pulse.
    assign snk_addr_o  = (wr_state_q == W_IDLE) ? dbb.wr_req_addr_i : wr_addr_q;
    assign snk_size_o  = {1'b0, ((wr_state_q == W_IDLE) ? dbb.wr_req_len_i : wr_len_q)} + ONE;
    assign snk_data_o  = dbb.wr_dat_data_i;
    assign snk_strb_o  = dbb.wr_dat_strb_i;
    assign dbb.wr_rsp_id_o = wr_id_q;
    assign wr_err_o    = wr_err_q;

    always_comb begin
        wr_state_d         = wr_state_q;
        wr_addr_d          = wr_addr_q;
        wr_len_d           = wr_len_q;
        wr_id_d            = wr_id_q;
        wr_err_d           = wr_err_q;
        wr_cnt_clr         = 1'b0;
        wr_cnt_inc         = 1'b0;
        dbb.wr_req_ready_o = 1'b0;
        dbb.wr_dat_ready_o = 1'b0;
        dbb.wr_rsp_valid_o = 1'b0;
        snk_start_o        = 1'b0;
        snk_valid_o        = 1'b0;

        unique case (wr_state_q)
            W_IDLE: begin
                if (dbb.wr_req_valid_i && snk_ready_i) begin
                    dbb.wr_req_ready_o = 1'b1;
                    snk_start_o        = 1'b1;
                    wr_addr_d          = dbb.wr_req_addr_i;
                    wr_len_d           = dbb.wr_req_len_i;
                    wr_id_d            = dbb.wr_req_id_i;
                    wr_cnt_clr         = 1'b1;
                    wr_state_d         = W_DATA;
                end
            end
            W_DATA: begin
                snk_valid_o        = dbb.wr_dat_valid_i;
                dbb.wr_dat_ready_o = snk_ready_i_s;
                if (dbb.wr_dat_valid_i && snk_ready_i_s) begin
                    wr_cnt_inc = 1'b1;
                    // The counted length is authoritative; a disagreeing
                    // 'last' only raises the sticky flag.
                    if (dbb.wr_dat_last_i != wr_is_last) begin
                        wr_err_d = 1'b1;
                    end
                    if (wr_is_last) begin
                        wr_cnt_clr = 1'b1;
                        wr_state_d = W_DRAIN;
                    end
                end
            end
            W_DRAIN: begin
                // Sink reports idle only once all stores are committed.
                if (snk_ready_i) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                dbb.wr_rsp_valid_o = 1'b1;
                if (dbb.wr_rsp_ready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        // Soft clear aborts any burst without a response and drops the
        // sticky error; no handshake is offered in the clear cycle.
        if (clear_i) begin
            wr_state_d         = W_IDLE;
            wr_addr_d          = '0;
            wr_len_d           = '0;
            wr_id_d            = '0;
            wr_err_d           = 1'b0;
            wr_cnt_clr         = 1'b1;
            wr_cnt_inc         = 1'b0;
            dbb.wr_req_ready_o = 1'b0;
            dbb.wr_dat_ready_o = 1'b0;
            dbb.wr_rsp_valid_o = 1'b0;
            snk_start_o        = 1'b0;
            snk_valid_o        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_id_q    <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_id_q    <= wr_id_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign src_addr_o        = (rd_state_q == R_IDLE) ? dbb.rd_req_addr_i : rd_addr_q;
    assign src_size_o        = {1'b0, ((rd_state_q == R_IDLE) ? dbb.rd_req_len_i : rd_len_q)} + ONE;
    assign dbb.rd_dat_data_o = src_data_i;
    assign dbb.rd_dat_id_o   = rd_id_q;

    always_comb begin
        rd_state_d         = rd_state_q;
        rd_addr_d          = rd_addr_q;
        rd_len_d           = rd_len_q;
        rd_id_d            = rd_id_q;
        rd_cnt_clr         = 1'b0;
        rd_cnt_inc         = 1'b0;
        dbb.rd_req_ready_o = 1'b0;
        dbb.rd_dat_valid_o = 1'b0;
        dbb.rd_dat_last_o  = 1'b0;
        src_start_o        = 1'b0;
        src_ready_o        = 1'b0;

        unique case (rd_state_q)
            R_IDLE: begin
                if (dbb.rd_req_valid_i && src_ready_i) begin
                    dbb.rd_req_ready_o = 1'b1;
                    src_start_o        = 1'b1;
                    rd_addr_d          = dbb.rd_req_addr_i;
                    rd_len_d           = dbb.rd_req_len_i;
                    rd_id_d            = dbb.rd_req_id_i;
                    rd_cnt_clr         = 1'b1;
                    rd_state_d         = R_DATA;
                end
            end
            R_DATA: begin
                dbb.rd_dat_valid_o = src_valid_i;
                src_ready_o        = dbb.rd_dat_ready_i;
                dbb.rd_dat_last_o  = rd_is_last;
                if (src_valid_i && dbb.rd_dat_ready_i) begin
                    rd_cnt_inc = 1'b1;
                    if (rd_is_last) begin
                        rd_cnt_clr = 1'b1;
                        rd_state_d = R_DONE;
                    end
                end
            end
            R_DONE: begin
                if (src_ready_i) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (clear_i) begin
            rd_state_d         = R_IDLE;
            rd_addr_d          = '0;
            rd_len_d           = '0;
            rd_id_d            = '0;
            rd_cnt_clr         = 1'b1;
            rd_cnt_inc         = 1'b0;
            dbb.rd_req_ready_o = 1'b0;
            dbb.rd_dat_valid_o = 1'b0;
            dbb.rd_dat_last_o  = 1'b0;
            src_start_o        = 1'b0;
            src_ready_o        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_id_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign idle_o = (wr_state_q == W_IDLE) && (rd_state_q == R_IDLE);

endmodule

// File: tb/tb_nvdla_dbb_duplex_bridge.sv
// Self-checking bench for nvdla_dbb_duplex_bridge: a table of write/read
// bursts applied in a loop, plus hand-written concurrent and clear sequences.
module tb_nvdla_dbb_duplex_bridge;
    import nvdla_dbb_duplex_bridge_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear;
    logic        snk_start, snk_ready, snk_valid, snk_ready_s;
    logic [31:0] snk_addr, snk_data;
    logic [4:0]  snk_size;
    logic [3:0]  snk_strb;
    logic        src_start, src_ready, src_valid, src_ready_o;
    logic [31:0] src_addr, src_data;
    logic [4:0]  src_size;
    logic        wr_err, idle;

    nvdla_dbb_duplex_bridge_if dbb_if ();

    nvdla_dbb_duplex_bridge dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .dbb           (dbb_if.slave),
        .snk_start_o   (snk_start),
        .snk_ready_i   (snk_ready),
        .snk_addr_o    (snk_addr),
        .snk_size_o    (snk_size),
        .snk_valid_o   (snk_valid),
        .snk_ready_i_s (snk_ready_s),
        .snk_data_o    (snk_data),
        .snk_strb_o    (snk_strb),
        .src_start_o   (src_start),
        .src_ready_i   (src_ready),
        .src_addr_o    (src_addr),
        .src_size_o    (src_size),
        .src_valid_i   (src_valid),
        .src_ready_o   (src_ready_o),
        .src_data_i    (src_data),
        .wr_err_o      (wr_err),
        .idle_o        (idle)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [7:0]  id;
        int          last_at;   // write beat index carrying 'last'
        bit          bp;        // toggle the downstream ready every cycle
        logic [31:0] seed;      // beat b carries seed + b*0x01010101
        logic [4:0]  exp_size;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];
    int tests_run = 0;
    int failed    = 0;
    int snk_hs = 0, src_hs = 0, rsp_hs = 0;

    always @(posedge clk) begin
        if (snk_valid && snk_ready_s) snk_hs <= snk_hs + 1;
        if (src_valid && src_ready_o) src_hs <= src_hs + 1;
        if (dbb_if.wr_rsp_valid_o && dbb_if.wr_rsp_ready_i) rsp_hs <= rsp_hs + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v, input bit chk_idle);
        int b, cyc, hs0;
        logic [31:0] d;
        logic rs;
        hs0 = snk_hs;
        @(negedge clk);
        dbb_if.wr_req_valid_i = 1'b1;
        dbb_if.wr_req_addr_i  = v.addr;
        dbb_if.wr_req_len_i   = v.len;
        dbb_if.wr_req_id_i    = v.id;
        snk_ready = 1'b1;
        #1;
        chk("wr_req_ready", dbb_if.wr_req_ready_o, 1);
        chk("snk_start", snk_start, 1);
        chk("snk_addr", snk_addr, v.addr);
        chk("snk_size", snk_size, v.exp_size);
        @(negedge clk);
        snk_ready = 1'b0;
        #1;
        chk("wr_req_held", dbb_if.wr_req_ready_o, 0);
        chk("snk_start_once", snk_start, 0);
        dbb_if.wr_req_valid_i = 1'b0;
        b = 0;
        cyc = 0;
        while (b <= int'(v.len) && cyc < 200) begin
            d = v.seed + 32'(b) * 32'h01010101;
            dbb_if.wr_dat_valid_i = 1'b1;
            dbb_if.wr_dat_data_i  = d;
            dbb_if.wr_dat_strb_i  = 4'hF ^ 4'(b);
            dbb_if.wr_dat_last_i  = (b == v.last_at);
            rs = v.bp ? cyc[0] : 1'b1;
            snk_ready_s = rs;
            #1;
            chk("snk_valid", snk_valid, 1);
            chk("snk_data", snk_data, d);
            chk("snk_strb", snk_strb, 4'hF ^ 4'(b));
            chk("wr_dat_ready", dbb_if.wr_dat_ready_o, rs);
            @(negedge clk);
            if (rs) b++;
            cyc++;
        end
        chk("wr_beats", b, int'(v.len) + 1);
        dbb_if.wr_dat_valid_i = 1'b0;
        dbb_if.wr_dat_last_i  = 1'b0;
        snk_ready_s = 1'b0;
        #1;
        chk("wr_drain_no_rsp", dbb_if.wr_rsp_valid_o, 0);
        chk("snk_beat_count", snk_hs - hs0, int'(v.len) + 1);
        @(negedge clk);
        snk_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("wr_rsp_valid", dbb_if.wr_rsp_valid_o, 1);
        chk("wr_rsp_id", dbb_if.wr_rsp_id_o, v.id);
        chk("wr_err", wr_err, v.exp_err);
        @(negedge clk);
        #1;
        chk("wr_rsp_hold", dbb_if.wr_rsp_valid_o, 1);
        chk("wr_rsp_id_hold", dbb_if.wr_rsp_id_o, v.id);
        dbb_if.wr_rsp_ready_i = 1'b1;
        @(negedge clk);
        dbb_if.wr_rsp_ready_i = 1'b0;
        #1;
        chk("wr_rsp_done", dbb_if.wr_rsp_valid_o, 0);
        if (chk_idle) chk("wr_idle", idle, 1);
        $display("[TB] write id=%0h len=%0d done", v.id, v.len);
    endtask

    task automatic do_read(input vec_t v, input bit chk_idle);
        int b, cyc, hs0;
        logic [31:0] d;
        logic rr;
        hs0 = src_hs;
        @(negedge clk);
        dbb_if.rd_req_valid_i = 1'b1;
        dbb_if.rd_req_addr_i  = v.addr;
        dbb_if.rd_req_len_i   = v.len;
        dbb_if.rd_req_id_i    = v.id;
        src_ready = 1'b1;
        #1;
        chk("rd_req_ready", dbb_if.rd_req_ready_o, 1);
        chk("src_start", src_start, 1);
        chk("src_addr", src_addr, v.addr);
        chk("src_size", src_size, v.exp_size);
        @(negedge clk);
        src_ready = 1'b0;
        #1;
        chk("rd_req_held", dbb_if.rd_req_ready_o, 0);
        dbb_if.rd_req_valid_i = 1'b0;
        b = 0;
        cyc = 0;
        while (b <= int'(v.len) && cyc < 200) begin
            d = v.seed + 32'(b) * 32'h01010101;
            src_valid = 1'b1;
            src_data  = d;
            rr = v.bp ? cyc[0] : 1'b1;
            dbb_if.rd_dat_ready_i = rr;
            #1;
            chk("rd_dat_valid", dbb_if.rd_dat_valid_o, 1);
            chk("rd_dat_data", dbb_if.rd_dat_data_o, d);
            chk("rd_dat_id", dbb_if.rd_dat_id_o, v.id);
            chk("rd_dat_last", dbb_if.rd_dat_last_o, (b == int'(v.len)));
            chk("src_ready", src_ready_o, rr);
            @(negedge clk);
            if (rr) b++;
            cyc++;
        end
        chk("rd_beats", b, int'(v.len) + 1);
        src_valid = 1'b0;
        dbb_if.rd_dat_ready_i = 1'b0;
        #1;
        chk("rd_done_no_valid", dbb_if.rd_dat_valid_o, 0);
        chk("src_beat_count", src_hs - hs0, int'(v.len) + 1);
        if (chk_idle) chk("rd_done_busy", idle, 0);
        src_ready = 1'b1;
        @(negedge clk);
        #1;
        if (chk_idle) chk("rd_idle", idle, 1);
        $display("[TB] read id=%0h len=%0d done", v.id, v.len);
    endtask

    initial begin
        vec_t w, r;
        int hs0, rsp0;

        vecs[0] = '{1'b1, 32'h0000_1000, 4'd0,  8'h5A, 0,  1'b0, 32'hDEADBEEF, 5'd1,  1'b0};
        vecs[1] = '{1'b0, 32'h0000_2000, 4'd15, 8'hC3, 0,  1'b0, 32'h1000_0000, 5'd16, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_3000, 4'd5,  8'h11, 5,  1'b1, 32'h2000_0000, 5'd6,  1'b0};
        vecs[3] = '{1'b0, 32'h0000_4000, 4'd2,  8'h22, 0,  1'b1, 32'h3000_0000, 5'd3,  1'b0};
        vecs[4] = '{1'b1, 32'h0000_4400, 4'd15, 8'h33, 15, 1'b0, 32'h4000_0000, 5'd16, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_4800, 4'd3,  8'h44, 1,  1'b0, 32'h5000_0000, 5'd4,  1'b1};

        rst_n = 1'b0; clear = 1'b0;
        snk_ready = 1'b1; snk_ready_s = 1'b0;
        src_ready = 1'b1; src_valid = 1'b0; src_data = '0;
        dbb_if.wr_req_valid_i = 1'b0; dbb_if.wr_req_addr_i = '0;
        dbb_if.wr_req_len_i = '0; dbb_if.wr_req_id_i = '0;
        dbb_if.wr_dat_valid_i = 1'b0; dbb_if.wr_dat_data_i = '0;
        dbb_if.wr_dat_strb_i = '0; dbb_if.wr_dat_last_i = 1'b0;
        dbb_if.wr_rsp_ready_i = 1'b0;
        dbb_if.rd_req_valid_i = 1'b0; dbb_if.rd_req_addr_i = '0;
        dbb_if.rd_req_len_i = '0; dbb_if.rd_req_id_i = '0;
        dbb_if.rd_dat_ready_i = 1'b0;

        #12;
        chk("rst_idle", idle, 1);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_rsp_valid", dbb_if.wr_rsp_valid_o, 0);
        chk("rst_rd_valid", dbb_if.rd_dat_valid_o, 0);
        chk("rst_snk_start", snk_start, 0);
        chk("rst_src_start", src_start, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i], 1'b1);
            else               do_read(vecs[i], 1'b1);
        end

        // Concurrent: both requests presented in the same cycle; the error
        // flag from the previous mismatch burst is still set.
        w = '{1'b1, 32'h0000_6000, 4'd3, 8'hA1, 3, 1'b0, 32'h6000_0000, 5'd4, 1'b1};
        r = '{1'b0, 32'h0000_7000, 4'd7, 8'hB2, 0, 1'b1, 32'h7000_0000, 5'd8, 1'b0};
        fork
            do_write(w, 1'b0);
            do_read(r, 1'b0);
        join
        @(negedge clk);
        #1;
        chk("conc_idle", idle, 1);

        // Clear in the middle of an 8-beat write.
        hs0  = snk_hs;
        rsp0 = rsp_hs;
        @(negedge clk);
        dbb_if.wr_req_valid_i = 1'b1;
        dbb_if.wr_req_addr_i  = 32'h0000_8000;
        dbb_if.wr_req_len_i   = 4'd7;
        dbb_if.wr_req_id_i    = 8'h77;
        snk_ready = 1'b1;
        #1;
        chk("clr_req_ready", dbb_if.wr_req_ready_o, 1);
        @(negedge clk);
        dbb_if.wr_req_valid_i = 1'b0;
        snk_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dbb_if.wr_dat_valid_i = 1'b1;
            dbb_if.wr_dat_data_i  = 32'(k);
            snk_ready_s = 1'b1;
            @(negedge clk);
        end
        dbb_if.wr_dat_valid_i = 1'b0;
        snk_ready_s = 1'b0;
        #1;
        chk("clr_busy_before", idle, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_idle", idle, 1);
        chk("clr_wr_err", wr_err, 0);
        chk("clr_no_rsp", dbb_if.wr_rsp_valid_o, 0);
        chk("clr_beats", snk_hs - hs0, 2);
        snk_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("clr_rsp_count", rsp_hs - rsp0, 0);
        $display("[TB] clear mid-burst done");

        // A fresh write after the clear completes normally with no error.
        w = '{1'b1, 32'h0000_9000, 4'd0, 8'h66, 0, 1'b0, 32'hCAFEF00D, 5'd1, 1'b0};
        do_write(w, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
